// File: rtl/tmp_fir_feeder_pkg.sv
// tmp_fir_feeder_pkg
//   Shared types and defaults for the tmp_fir_feeder block.
//   - state_t            : feeder FSM states (IDLE, WAIT)
//   - DEF_WII / DEF_WFI  : default integer / fraction bits of a sample
//   - DEF_SW             : default sample width
//   - default_timeout()  : default watchdog limit for a given FIR cycle count
package tmp_fir_feeder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int DEF_WII = 2;
  localparam int DEF_WFI = 10;
  localparam int DEF_SW  = DEF_WII + DEF_WFI;

  // Twice the accumulation length plus slack for the issue/return hops.
  function automatic int default_timeout(input int cycle_num);
    return 2 * cycle_num + 8;
  endfunction

endpackage

// File: rtl/tmp_fir_feeder_fifo.sv
// fir_sample_fifo
//   Synchronous FIFO holding samples waiting to be issued to the FIR.
//   Head is read straight from storage, so a sample written at an edge is
//   visible at the head from the next cycle on (no bypass path).
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset (empties FIFO)
//   i_push, i_data    : write strobe and data (caller guarantees !o_full)
//   i_pop             : read strobe (caller guarantees !o_empty)
//   o_head            : oldest stored entry
//   o_count           : occupancy, 0..DEPTH
//   o_full, o_empty   : occupancy flags
module fir_sample_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
  // modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/tmp_fir_feeder.sv
// tmp_fir_feeder
//   Stream-side initiator for the time-multiplexed FIR. Buffers incoming
//   samples, issues them one at a time to the FIR (holding x stable for the
//   whole accumulation) and returns each result on a valid/ready port.
//
// Handshakes: a transfer happens on a cycle where both valid and ready are
//   high. s_valid/s_data are held by upstream until accepted; m_valid/m_data
//   are held here until m_ready. fir_in_valid is a one-cycle strobe and
//   fir_out_valid is a one-cycle strobe from the FIR; neither has a ready.
//
// Ports:
//   CLK, RST_N        : clock, synchronous active-low reset
//   s_data/s_valid/s_ready : sample input port
//   fir_rst           : active-high reset to the FIR (~RST_N)
//   fir_x/fir_in_valid: sample and issue strobe to the FIR (registered)
//   fir_y/fir_out_valid : result and result strobe from the FIR
//   m_data/m_valid/m_ready : result output port (registered)
//   busy              : work pending anywhere in the block
//   timeout_err       : sticky watchdog flag
//   dbg_state         : current FSM state, for observation only
//
// Build option: define TMP_FIR_FEEDER_TIMEOUT_EN to build the WAIT watchdog.
//   Without it, timeout_err is tied 0 and WAIT lasts until fir_out_valid.
module tmp_fir_feeder
  import tmp_fir_feeder_pkg::*;
#(
  parameter int WII       = DEF_WII,
  parameter int WFI       = DEF_WFI,
  parameter int WIO       = WII,
  parameter int WFO       = WFI,
  parameter int CYCLE_NUM = 4,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = default_timeout(CYCLE_NUM)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [WII+WFI-1:0]   s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 fir_rst,
  output logic [WII+WFI-1:0]   fir_x,
  output logic                 fir_in_valid,
  input  logic [WIO+WFO-1:0]   fir_y,
  input  logic                 fir_out_valid,
  output logic [WIO+WFO-1:0]   m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 timeout_err,
  output state_t               dbg_state
);

  localparam int SW = WII + WFI;
  localparam int OW = WIO + WFO;
  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_cfg_check
    $error("tmp_fir_feeder: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  state_t        r_state;
  state_t        w_next_state;
  logic          w_issue;
  logic          w_load;
  logic          w_timeout;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic [SW-1:0] w_head;
  logic [CW-1:0] w_count;

  logic [SW-1:0] r_fir_x;
  logic          r_fir_in_valid;
  logic [OW-1:0] r_m_data;
  logic          r_m_valid;

  assign fir_rst = ~RST_N;
  assign s_ready = RST_N & ~w_full;
  assign w_push  = s_valid & s_ready;

  fir_sample_fifo #(
    .W     (SW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_push  (w_push),
    .i_data  (s_data),
    .i_pop   (w_issue),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Issue waits for room in the output register, which is what guarantees a
  // pending result is never overwritten by the next one.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && (!r_m_valid || m_ready)) begin
          w_issue      = 1'b1;
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        if (fir_out_valid) begin
          w_load       = 1'b1;
          w_next_state = IDLE;
        end else if (w_timeout) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // fir_x only changes on issue, so it stays put through the fir_out_valid
  // cycle while the FIR shifts it into its delay line.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_fir_x        <= '0;
      r_fir_in_valid <= 1'b0;
      r_m_data       <= '0;
      r_m_valid      <= 1'b0;
    end else begin
      r_fir_in_valid <= w_issue;
      if (w_issue) r_fir_x <= w_head;
      if (w_load) begin
        r_m_data  <= fir_y;
        r_m_valid <= 1'b1;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

`ifdef TMP_FIR_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wait_cnt;
  logic          r_timeout_err;

  // Counter holds the number of WAIT cycles already elapsed; a result
  // arriving on the final cycle still wins over the watchdog.
  assign w_timeout = (r_state == WAIT) && !fir_out_valid &&
                     (r_wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + TW'(1);
      else                 r_wait_cnt <= '0;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign fir_x        = r_fir_x;
  assign fir_in_valid = r_fir_in_valid;
  assign m_data       = r_m_data;
  assign m_valid      = r_m_valid;
  assign busy         = (r_state != IDLE) || (w_count != '0) || r_m_valid;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_tmp_fir_feeder.sv
// tb_tmp_fir_feeder
//   Directed bench for tmp_fir_feeder with an identity-response FIR model.
//   Expected results are queued when a sample is accepted and checked in
//   order by an independent monitor on every m_valid && m_ready transfer.
module tb_tmp_fir_feeder;
  import tmp_fir_feeder_pkg::*;

  localparam int CN    = 4;
  localparam int DEPTH = 4;
  localparam int SW    = 12;

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [SW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          fir_rst;
  logic [SW-1:0] fir_x;
  logic          fir_in_valid;
  logic [SW-1:0] fir_y;
  logic          fir_out_valid;
  logic [SW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          timeout_err;
  state_t        dbg_state;

  tmp_fir_feeder #(
    .CYCLE_NUM (CN),
    .DEPTH     (DEPTH)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .fir_rst       (fir_rst),
    .fir_x         (fir_x),
    .fir_in_valid  (fir_in_valid),
    .fir_y         (fir_y),
    .fir_out_valid (fir_out_valid),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [SW-1:0] exp_q[$];
  int            issue_q[$];
  int            mv_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            fir_mute = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- FIR model: identity response ----------------
  // Result strobe comes CN+2 cycles after the issue strobe, which puts
  // out_valid at cycle CN+4 relative to sample acceptance.
  int            fir_cnt = 0;
  logic [SW-1:0] fir_cap = '0;
  initial begin
    fir_out_valid = 1'b0;
    fir_y         = '0;
    forever begin
      @(posedge CLK); #2;
      if (fir_rst) begin
        fir_cnt       = 0;
        fir_out_valid = 1'b0;
      end else begin
        fir_out_valid = 1'b0;
        if (fir_cnt > 0) begin
          check("fir_x_stable", 32'(fir_x), 32'(fir_cap));
          fir_cnt--;
          if (fir_cnt == 0 && !fir_mute) begin
            fir_out_valid = 1'b1;
            fir_y         = fir_cap;
          end
        end
        if (fir_in_valid) begin
          check("issue_while_busy", 32'(fir_cnt), 32'(0));
          fir_cap = fir_x;
          fir_cnt = CN + 2;
          issue_q.push_back(cyc);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic          mv_prev;
    logic [SW-1:0] e;
    mv_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (m_valid && !mv_prev) mv_q.push_back(cyc);
      mv_prev = m_valid;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL m_unexpected: got result %0h with nothing expected (cycle %0d)", m_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end at posedge+1 so inputs never change at an edge.
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [SW-1:0] d, input bit expect_out,
                      output int t_acc, output int stalls);
    stalls  = 0;
    t_acc   = -1;
    s_data  = d;
    s_valid = 1'b1;
    @(negedge CLK);
    while (!s_ready && stalls < 200) begin
      @(negedge CLK);
      stalls++;
    end
    if (s_ready) begin
      t_acc = cyc;
      if (expect_out) exp_q.push_back(d);
    end else begin
      check("send_accept", 32'(s_ready), 32'(1));
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || m_valid) && g < 400) begin
      @(negedge CLK);
      g++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'(0));
    step();
  endtask

  task automatic wait_mvalid(input string name);
    int g;
    g = 0;
    @(negedge CLK);
    while (!m_valid && g < 100) begin
      @(negedge CLK);
      g++;
    end
    check({name, "_mvalid"}, 32'(m_valid), 32'(1));
    step();
  endtask

  task automatic do_reset();
    step();
    RST_N = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, st, t_d, st_sum, n_mv, t_err, g;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    RST_N   = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_fir_rst",  32'(fir_rst), 32'(1));
    check("rst_s_ready",  32'(s_ready), 32'(0));
    check("rst_fir_x",    32'(fir_x), 32'(0));
    check("rst_in_valid", 32'(fir_in_valid), 32'(0));
    check("rst_m_valid",  32'(m_valid), 32'(0));
    check("rst_m_data",   32'(m_data), 32'(0));
    check("rst_busy",     32'(busy), 32'(0));
    check("rst_timeout",  32'(timeout_err), 32'(0));
    step();
    RST_N   = 1'b1;
    m_ready = 1'b1;

    // T1: single sample latency
    issue_q.delete();
    mv_q.delete();
    send(12'h100, 1'b1, t, st);
    wait_drain("t1");
    check("t1_issue_count", 32'(issue_q.size()), 32'(1));
    check("t1_issue_lat",   32'(issue_q[0] - t), 32'(2));
    check("t1_mvalid_lat",  32'(mv_q[0] - t), 32'(CN + 5));

    // T2: burst of 6, back-pressure after 5, issue every CN+4 cycles
    issue_q.delete();
    st_sum = 0;
    for (int i = 1; i <= 6; i++) begin
      send(SW'(i), 1'b1, t, st);
      if (i <= 5) st_sum += st;
      else check("t2_sready_drop", 32'(st > 0), 32'(1));
    end
    check("t2_first5_nostall", 32'(st_sum), 32'(0));
    wait_drain("t2");
    check("t2_issue_count", 32'(issue_q.size()), 32'(6));
    for (int i = 1; i < 6; i++) check("t2_issue_period", 32'(issue_q[i] - issue_q[i-1]), 32'(CN + 4));

    // T3: downstream stall holds issue, FIFO fills to DEPTH
    do_reset();
    m_ready = 1'b0;
    issue_q.delete();
    send(12'h0A1, 1'b1, t, st);
    wait_mvalid("t3");
    for (int i = 2; i <= 5; i++) send(SW'(12'h0A0 + i), 1'b1, t, st);
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    check("t3_s_ready_full", 32'(s_ready), 32'(0));
    check("t3_issue_held",   32'(issue_q.size()), 32'(1));
    check("t3_m_valid_held", 32'(m_valid), 32'(1));
    check("t3_busy",         32'(busy), 32'(1));
    step();
    m_ready = 1'b1;
    wait_drain("t3");
    check("t3_issue_count", 32'(issue_q.size()), 32'(5));

    // T4: reset in the middle of WAIT, with one sample still queued
    issue_q.delete();
    send(12'h3C3, 1'b1, t, st);
    send(12'h2B2, 1'b1, t, st);
    @(negedge CLK);
    check("t4_in_wait", 32'(dbg_state), 32'(WAIT));
    step();
    RST_N = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    check("t4_fir_rst", 32'(fir_rst), 32'(1));
    check("t4_s_ready", 32'(s_ready), 32'(0));
    @(negedge CLK);
    check("t4_fir_x",    32'(fir_x), 32'(0));
    check("t4_in_valid", 32'(fir_in_valid), 32'(0));
    check("t4_m_data",   32'(m_data), 32'(0));
    check("t4_m_valid",  32'(m_valid), 32'(0));
    check("t4_busy",     32'(busy), 32'(0));
    check("t4_state",    32'(dbg_state), 32'(IDLE));
    step();
    RST_N = 1'b1;
    n_mv  = mv_q.size();
    repeat (20) step();
    check("t4_no_stale_mvalid", 32'(mv_q.size()), 32'(n_mv));
    check("t4_no_reissue",      32'(issue_q.size()), 32'(1));

    // T5: push in the same cycle as an issue pop with two queued
    do_reset();
    m_ready = 1'b0;
    issue_q.delete();
    send(12'h011, 1'b1, t, st);
    wait_mvalid("t5");
    send(12'h022, 1'b1, t, st);
    send(12'h033, 1'b1, t, st);
    m_ready = 1'b1;
    send(12'h044, 1'b1, t_d, st);
    check("t5_push_d", 32'(st), 32'(0));
    send(12'h055, 1'b1, t, st);
    check("t5_push_e", 32'(st), 32'(0));
    send(12'h066, 1'b1, t, st);
    check("t5_push_f", 32'(st), 32'(0));
    @(negedge CLK);
    check("t5_full_at_4", 32'(s_ready), 32'(0));
    check("t5_issue_same_cycle", 32'(issue_q[1] - t_d), 32'(1));
    step();
    wait_drain("t5");
    check("t5_issue_count", 32'(issue_q.size()), 32'(6));

`ifdef TMP_FIR_FEEDER_TIMEOUT_EN
    // T6: FIR never answers; watchdog fires after 16 WAIT cycles
    issue_q.delete();
    fir_mute = 1'b1;
    send(12'h155, 1'b0, t, st);
    g = 0;
    @(negedge CLK);
    while (!timeout_err && g < 100) begin
      @(negedge CLK);
      g++;
    end
    t_err = cyc;
    check("t6_timeout_set", 32'(timeout_err), 32'(1));
    check("t6_timeout_lat", 32'(t_err - issue_q[0]), 32'(2 * CN + 8));
    step();
    fir_mute = 1'b0;
    send(12'h266, 1'b1, t, st);
    wait_drain("t6");
    check("t6_timeout_sticky", 32'(timeout_err), 32'(1));
    check("t6_issue_count",    32'(issue_q.size()), 32'(2));
`else
    // T6: without the watchdog the flag stays low
    send(12'h155, 1'b1, t, st);
    wait_drain("t6");
    check("t6_timeout_low", 32'(timeout_err), 32'(0));
`endif

    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tmp_fir_feeder.md
# tmp_fir_feeder

Stream-side initiator for the time-multiplexed FIR (`tmp_fir`). It accepts input samples on a valid/ready slave port and buffers them in a small FIFO. It issues them to the FIR one at a time using the FIR's `in_valid`/`out_valid` protocol, holding `x` stable for the whole accumulation, and returns each filtered result on a valid/ready master port. It sits between the upstream sample source and `tmp_fir`, so the FIR never sees a sample while busy and no result is overwritten.

## Interface
- `WII`, 2: integer bits of input sample.
- `WFI`, 10: fraction bits of input sample.
- `WIO`, `WII`: integer bits of FIR output.
- `WFO`, `WFI`: fraction bits of FIR output.
- `CYCLE_NUM`, 4: FIR accumulation cycles (N/M of the attached FIR).
- `DEPTH`, 4: input FIFO depth; power of two, ≥2.
- `TIMEOUT`, 2*CYCLE_NUM+8: watchdog limit in cycles spent in WAIT.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: synchronous reset, active low.
- `s_data` in WII+WFI: signed input sample.
- `s_valid` in 1: upstream sample valid.
- `s_ready` out 1: FIFO can accept a sample.
- `fir_rst` out 1: `~RST_N`, combinational; drives the FIR's active-high `RST`.
- `fir_x` out WII+WFI: sample to FIR, registered.
- `fir_in_valid` out 1: single-cycle issue strobe, registered.
- `fir_y` in WIO+WFO: FIR result.
- `fir_out_valid` in 1: FIR result strobe.
- `m_data` out WIO+WFO: filtered result, registered.
- `m_valid` out 1: result valid.
- `m_ready` in 1: downstream accepts result.
- `busy` out 1: `state!=IDLE || count!=0 || m_valid`.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- Input FIFO:
  - `s_ready = (count < DEPTH)`; forced 0 while `RST_N` is low.
  - Push on `s_valid && s_ready`.
  - Push and pop in the same cycle leaves `count` unchanged.
  - Pointers wrap modulo DEPTH.
  - No bypass: a sample pushed in cycle c is issuable in cycle c+1 at the earliest.
- FSM states: IDLE, WAIT.
- IDLE: issue only when `count != 0` and `(!m_valid || m_ready)`. On issue:
  - `fir_x <= head`
  - pop the FIFO
  - `fir_in_valid <= 1`
  - go to WAIT.
- WAIT:
  - `fir_in_valid <= 0`; `fir_x` held unchanged.
  - On `fir_out_valid`: `m_data <= fir_y`, `m_valid <= 1`, go to IDLE.
- `fir_x` must remain stable through the `fir_out_valid` cycle, because the FIR shifts `x` into its delay line at the end of that cycle. The earliest `fir_x` update is the IDLE cycle that follows.
- Output register: `m_valid` clears on `m_ready` unless reloaded in the same cycle. A result is never overwritten; this is guaranteed by the issue condition.
- `fir_out_valid` arriving in IDLE is ignored.
- No arithmetic: the block passes samples and results through at their declared widths.
- Reset (`RST_N=0` at an edge, including mid-WAIT):
  - State: IDLE; FIFO emptied.
  - Outputs: `fir_x=0`, `fir_in_valid=0`, `m_data=0`, `m_valid=0`, `timeout_err=0`, `s_ready=0`.
  - The in-flight sample is discarded; the FIR is reset simultaneously via `fir_rst`.

## Timing
- Sample accepted in cycle 0 → `fir_in_valid` high in cycle 2 → FIR `out_valid` in cycle CYCLE_NUM+4 → `m_valid` in cycle CYCLE_NUM+5 (cycle 9 at defaults).
- With the FIFO non-empty and the output drained, `fir_in_valid` pulses every CYCLE_NUM+4 cycles.
- Sustained input throughput is one sample per CYCLE_NUM+4 cycles; excess upstream rate back-pressures via `s_ready`.
- `m_valid && !m_ready` stalls issue; the FIFO keeps accepting samples until full.

## Configuration
- `TMP_FIR_FEEDER_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs.
  - Reaching TIMEOUT sets `timeout_err=1` (sticky until reset), returns to IDLE and drops the sample; no `m_valid` is produced for it.
- Undefined:
  - No counter is built and `timeout_err` is tied 0.
  - WAIT persists until `fir_out_valid`.

## Structure
- `tmp_fir_feeder_pkg`:
  - state enum (IDLE, WAIT)
  - default width localparams (`WII`, `WFI`, sample width)
  - `default_timeout(CYCLE_NUM)` function.
- Sub-module `fir_sample_fifo`: synchronous FIFO, DEPTH and width parameters, push/pop/count/head.
- FSM and output register live in the top.

## Test plan
- Single sample 12'h100, bench FIR model with identity response and CYCLE_NUM=4 → `fir_in_valid` in cycle 2; `m_data=12'h100`, `m_valid` in cycle 9; `fir_x` stable cycles 2–8.
- Burst of 6 samples 1..6 with `m_ready=1` → `s_ready` drops after 5 accepted; `fir_in_valid` every 8 cycles; outputs 1..6 in order.
- `m_ready=0` after the first result → no second `fir_in_valid` until `m_ready` pulses; no result lost; FIFO fills to 4 and `s_ready=0`.
- `RST_N` low during WAIT → next cycle: all outputs 0, `fir_rst=1` during reset, FIFO empty; no stale `m_valid` afterwards.
- With `TMP_FIR_FEEDER_TIMEOUT_EN` and the FIR model never asserting `out_valid` → `timeout_err=1` 16 cycles into WAIT; the next sample still issues.
- Push in the same cycle as an issue pop with `count=2` → `count` stays 2; head order preserved.
